seq_shifter: RTL and testbench

Iterative, multi-cycle shift/rotate unit: same operation set as the team's combinational barrel shifter, but the operand moves one bit position per clock in a single register. Accepts an operand and control word over a valid/ready input handshake, performs K single-bit steps, and presents the result over a valid/ready output handshake. It is the area-minimal sequential counterpart used where a full shifter network is not wanted and latency of up to WIDTH cycles is acceptable.

---
 rtl/seq_shifter.sv | 111 +++++++++++
 tb/tb_seq_shifter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shift/rotate unit, one bit position per clock.
// Operand and result move over valid/ready handshakes; latency is K+1 cycles.
module seq_shifter #(
    parameter int WIDTH = 4,
    parameter int KW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [KW-1:0]    K,
    input  logic             left,
    input  logic             arithmetic,
    input  logic             shift,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, step_val;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic             shift_q, shift_d;
    logic             sign_q, sign_d;
    logic             accept;

    assign in_ready  = reset_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out       = work_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // Single-position step of the work register
    always_comb begin
        step_val = work_q;
        unique casez ({shift_q, left_q, arith_q})
            3'b00?: step_val = {work_q[0], work_q[WIDTH-1:1]};
            3'b01?: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            3'b100: step_val = {1'b0, work_q[WIDTH-1:1]};
            3'b101: step_val = {sign_q, work_q[WIDTH-1:1]};
            3'b11?: step_val = {work_q[WIDTH-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        shift_d = shift_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = A;
                    cnt_d   = K;
                    left_d  = left;
                    arith_d = arithmetic;
                    shift_d = shift;
                    sign_d  = A[WIDTH-1];
                    state_d = (K == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
            shift_q <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
            shift_q <= shift_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed table, corner sequences and randomized
// operations against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W  = 4;
    localparam int KB = 2;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [KB-1:0] K;
    logic          left;
    logic          arithmetic;
    logic          shift;
    logic [W-1:0]  out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int checks;
    int failures;

    seq_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .K         (K),
        .left      (left),
        .arithmetic(arithmetic),
        .shift     (shift),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [KB-1:0] k;
        logic          l;
        logic          ar;
        logic          sh;
        logic [W-1:0]  exp_out;
        int            exp_lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Result of one K-position operation, computed directly
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                            input int k, input logic l,
                                            input logic ar, input logic sh);
        logic [2*W-1:0] d;
        d = {a, a};
        if (!sh) begin
            if (l) return d[2*W-1-k -: W];
            else   return d[k +: W];
        end
        if (l)  return W'(a << k);
        if (ar) return W'($signed(a) >>> k);
        return W'(a >> k);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [KB-1:0] k,
                          input logic l, input logic ar, input logic sh,
                          input int hold, output logic [W-1:0] res,
                          output int lat);
        int wc;
        A = a; K = k; left = l; arithmetic = ar; shift = sh;
        in_valid = 1'b1;
        out_ready = 1'b0;
        wc = 0;
        while (!in_ready && wc < 20) begin
            tick();
            wc++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        A = W'($urandom);
        K = KB'($urandom);
        left = 1'($urandom);
        arithmetic = 1'($urandom);
        shift = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 2 * W + 4) begin
            tick();
            lat++;
        end
        res = out;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out", 32'(out), 32'(res));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] e;
        int lat;
        int hold;
        logic [W-1:0] ra;
        logic [KB-1:0] rk;
        logic rl, rar, rsh;

        checks = 0;
        failures = 0;

        vecs[0] = '{4'b1011, 2'd2, 1'b0, 1'b0, 1'b0, 4'b1110, 3};
        vecs[1] = '{4'b1011, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0111, 2};
        vecs[2] = '{4'b1011, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001, 4};
        vecs[3] = '{4'b1011, 2'd2, 1'b0, 1'b1, 1'b1, 4'b1110, 3};
        vecs[4] = '{4'b0110, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0011, 2};
        vecs[5] = '{4'b1011, 2'd2, 1'b1, 1'b1, 1'b1, 4'b1100, 3};
        vecs[6] = '{4'b1011, 2'd2, 1'b1, 1'b0, 1'b1, 4'b1100, 3};
        vecs[7] = '{4'b1001, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1001, 1};
        vecs[8] = '{4'b1001, 2'd0, 1'b1, 1'b1, 1'b1, 4'b1001, 1};
        vecs[9] = '{4'b1000, 2'd3, 1'b0, 1'b1, 1'b1, 4'b1111, 4};

        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0; K = '0; left = 1'b0; arithmetic = 1'b0; shift = 1'b0;
        repeat (3) tick();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].k, vecs[i].l, vecs[i].ar,
                   vecs[i].sh, 0, res, lat);
            chk($sformatf("vec%0d_out", i), 32'(res), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Back-to-back K=0 with in_valid held high
        A = 4'b1001; K = 2'd0; left = 1'b0; arithmetic = 1'b0; shift = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk("b2b_ready_T", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_valid_T1", 32'(out_valid), 32'd1);
        chk("b2b_out_T1", 32'(out), 32'b1001);
        chk("b2b_ready_T1", 32'(in_ready), 32'd0);
        A = 4'b0011;
        tick();
        chk("b2b_ready_T2", 32'(in_ready), 32'd1);
        chk("b2b_valid_T2", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid_T3", 32'(out_valid), 32'd1);
        chk("b2b_out_T3", 32'(out), 32'b0011);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 32'(in_ready), 32'd1);

        // Backpressure with ignored in_valid pulses
        A = 4'b0101; K = 2'd1; left = 1'b0; arithmetic = 1'b0; shift = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_out", 32'(out), 32'b1010);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'(i % 2);
            A = 4'b1111; K = 2'd3; shift = 1'b1;
            tick();
            chk("bp_hold_out", 32'(out), 32'b1010);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of an arithmetic right shift
        A = 4'b1111; K = 2'd3; left = 1'b0; arithmetic = 1'b1; shift = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_stale", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Randomized operations against the reference model
        for (int n = 0; n < 200; n++) begin
            ra  = W'($urandom);
            rk  = KB'($urandom);
            rl  = 1'($urandom);
            rar = 1'($urandom);
            rsh = 1'($urandom);
            hold = int'($urandom_range(0, 3));
            e = ref_op(ra, int'(rk), rl, rar, rsh);
            run_op(ra, rk, rl, rar, rsh, hold, res, lat);
            chk($sformatf("rnd%0d_out", n), 32'(res), 32'(e));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(int'(rk) + 1));
            chk($sformatf("rnd%0d_idle", n), 32'(in_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
